mips_cpu_avalon_arbiter: RTL and testbench
==========================================

# mips_cpu_avalon_arbiter

Two-master to one-slave Avalon arbiter that shares the single unified memory port between the CPU instruction-fetch master and the data load/store master. Each master sees its own Avalon-style port with `waitrequest` stall semantics. The arbiter serialises their transactions onto the slave port, which connects to the memory or the testbench RAM. It holds each granted transaction until the slave drops `waitrequest`, then returns the slave's read data to the owning master.

## Interface
Parameters:
- `ADDR_W`, 32, address width on all ports
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `i_address`  in  ADDR_W  instruction master address
- `i_read`  in  1  instruction master read request (read-only master)
- `i_waitrequest`  out  1  stall to instruction master
- `i_readdata`  out  DATA_W  read data to instruction master
- `d_address`  in  ADDR_W  data master address
- `d_read` / `d_write`  in  1 each  data master requests; both high is illegal, and `d_write` wins
- `d_byteenable`  in  DATA_W/8  data master byte lanes
- `d_writedata`  in  DATA_W  data master write data
- `d_waitrequest`  out  1  stall to data master
- `d_readdata`  out  DATA_W  read data to data master
- `s_address`, `s_read`, `s_write`, `s_byteenable`, `s_writedata`  out  slave request bus (registered)
- `s_waitrequest`  in  1  slave stall
- `s_readdata`  in  DATA_W  slave read data

## Operation
- FSM states are `IDLE`, `ISSUE` and `WAIT`, plus a registered `owner` (`I` or `D`) and `last` (owner of the most recent completed transfer).
- IDLE:
  - If any master request is high, pick a winner (see Configuration).
  - Register the winner's address, byteenable, writedata and read/write onto the `s_*` outputs.
  - Set `owner`, then go to ISSUE.
  - An instruction read drives `s_byteenable` to all ones.
- ISSUE lasts exactly one cycle with `s_*` held. It then goes to WAIT unconditionally, so a stale low `s_waitrequest` sampled in the issue cycle is never taken as completion.
- WAIT:
  - Hold all `s_*` stable.
  - When `s_waitrequest`=0: completion. In the same cycle drive the owner's `*_waitrequest`=0 and pass `s_readdata` combinationally to the owner's `*_readdata`.
  - On the next edge: deassert `s_read`/`s_write`, set `last`=`owner`, return to IDLE.
- Master stall: `x_waitrequest` = request(x) AND NOT (state==WAIT AND owner==x AND `s_waitrequest`==0). It is 0 when the master is not requesting.
- `*_readdata` holds its last completed value when not completing. Reset value is 0.
- Master requests must stay stable while their `waitrequest` is high; the arbiter does not re-sample the address after grant.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `last`=I, all `s_*` outputs 0, `*_readdata` 0.
  - Reset mid-transaction abandons it. The slave request drops on the next edge, and a master still requesting is re-arbitrated after reset release.
- Minimum latency is 3 edges from request seen in IDLE to completion: IDLE→ISSUE→WAIT, with completion in the first WAIT cycle if `s_waitrequest`=0.
- Back-to-back transfers have one IDLE bubble between them, so minimum spacing is 3 cycles per transfer.
- Both masters requesting in the same IDLE cycle: exactly one is granted. The loser stays stalled and is granted in the next IDLE if still requesting.
- A request that arrives during ISSUE or WAIT waits for IDLE and is never dropped.

## Configuration
- `MIPS_CPU_ARB_ROUND_ROBIN_EN` defined: on contention the winner is the master that is not `last`. No starvation; the worst-case wait is one other transfer.
- Undefined: fixed priority, and the data master always wins on contention. The instruction master can starve under continuous data traffic.
- Uncontended requests are granted immediately in both modes.

## Structure
- Package `mips_cpu_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT}
  - `arb_owner_t` enum {OWNER_I, OWNER_D}
  - `ARB_NUM_MASTERS`=2
- Sub-module `mips_cpu_arb_select`: combinational winner pick from (`i_req`, `d_req`, `last`). The macro selects its algorithm.

## Test plan
- Single I read, addr 0xBFC00000, slave stall 0 cycles after issue → `s_read` high for 2 cycles. `i_waitrequest` drops on cycle 3 with `i_readdata` = slave word, and `s_byteenable`=4'hF.
- D write addr 0xBFC00010, be 4'b0011, data 0xDEADBEEF, slave stall 4 cycles → `s_*` stable throughout. `d_waitrequest` low for exactly one cycle at completion, and I stays idle.
- I and D request in the same cycle:
  - Fixed priority: D is served first, then I.
  - Round-robin with `last`=D: I is served first.
  - In both cases the loser completes exactly 3+stall cycles after the winner's completion edge.
- Continuous D traffic with I pending, ten transfers:
  - Round-robin: grants alternate D/I.
  - Fixed priority: I receives no grant while D keeps requesting.
- `rst_n` low during WAIT → the next edge clears `s_read`/`s_write`. After release the pending master is re-issued and completes with correct data.
- Slave `s_waitrequest` low during the ISSUE cycle, then high for 2 cycles → no completion at ISSUE. Completion occurs when WAIT sees low.

Source files
------------

// File: rtl/mips_cpu_arb_pkg.sv
// Shared types for the CPU instruction/data Avalon arbiter.
//   arb_state_t     : arbiter FSM state
//   arb_owner_t     : which master owns the slave port
//   ARB_NUM_MASTERS : number of masters sharing the slave port
package mips_cpu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } arb_state_t;

   typedef enum logic {
      OWNER_I,
      OWNER_D
   } arb_owner_t;

   localparam int ARB_NUM_MASTERS = 2;

endpackage

// File: rtl/mips_cpu_arb_select.sv
// Combinational winner pick between the instruction and data masters.
// Build option: MIPS_CPU_ARB_ROUND_ROBIN_EN
//   defined   : on contention the master that did not complete last wins
//   undefined : on contention the data master always wins
// Ports:
//   i_req, d_req : request from each master
//   last         : owner of the most recently completed transfer
//   grant_valid  : at least one master is requesting
//   grant        : selected master (meaningful when grant_valid)
module mips_cpu_arb_select
   import mips_cpu_arb_pkg::*;
(
   input  logic       i_req,
   input  logic       d_req,
   input  arb_owner_t last,
   output logic       grant_valid,
   output arb_owner_t grant
);

`ifndef MIPS_CPU_ARB_ROUND_ROBIN_EN
   // Fixed priority has no use for the history of completed transfers.
   logic unused_last;
   assign unused_last = (last == OWNER_D);
`endif

   always_comb begin
      grant_valid = i_req | d_req;
      grant       = OWNER_I;
      if (i_req && d_req) begin
`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
         grant = (last == OWNER_I) ? OWNER_D : OWNER_I;
`else
         grant = OWNER_D;
`endif
      end else if (d_req) begin
         grant = OWNER_D;
      end
   end

endmodule

// File: rtl/mips_cpu_avalon_arbiter.sv
// Two-master to one-slave Avalon arbiter: CPU instruction fetch (read-only)
// and data load/store share one memory port. Transactions are serialised;
// each grant is held on the registered s_* bus until the slave drops
// s_waitrequest, and the slave read data is returned to the owner.
// Build option: MIPS_CPU_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (default is fixed priority with the data master winning).
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   i_address, i_read               : instruction master request
//   i_waitrequest, i_readdata       : instruction master response
//   d_address, d_read, d_write,
//   d_byteenable, d_writedata       : data master request (d_write wins)
//   d_waitrequest, d_readdata       : data master response
//   s_address, s_read, s_write,
//   s_byteenable, s_writedata       : registered slave request bus
//   s_waitrequest, s_readdata       : slave response
//
// state | meaning
// IDLE  | no transfer; winner is latched onto s_* when anyone requests
// ISSUE | first cycle of the slave request; s_waitrequest ignored
// WAIT  | s_* held until s_waitrequest=0 completes the transfer
module mips_cpu_avalon_arbiter
   import mips_cpu_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     i_address,
   input  logic                  i_read,
   output logic                  i_waitrequest,
   output logic [DATA_W-1:0]     i_readdata,
   input  logic [ADDR_W-1:0]     d_address,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [DATA_W/8-1:0]   d_byteenable,
   input  logic [DATA_W-1:0]     d_writedata,
   output logic                  d_waitrequest,
   output logic [DATA_W-1:0]     d_readdata,
   output logic [ADDR_W-1:0]     s_address,
   output logic                  s_read,
   output logic                  s_write,
   output logic [DATA_W/8-1:0]   s_byteenable,
   output logic [DATA_W-1:0]     s_writedata,
   input  logic                  s_waitrequest,
   input  logic [DATA_W-1:0]     s_readdata
);

   arb_state_t        state, state_nxt;
   arb_owner_t        owner, last, grant;
   logic              grant_valid;
   logic              i_req, d_req;
   logic              completing, i_done, d_done;
   logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   mips_cpu_arb_select u_select (
      .i_req       (i_req),
      .d_req       (d_req),
      .last        (last),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // Completion is only recognised in WAIT, so a low s_waitrequest left
   // over from a previous slave cycle cannot finish a transfer at ISSUE.
   assign completing = (state == WAIT) && !s_waitrequest;
   assign i_done     = completing && (owner == OWNER_I);
   assign d_done     = completing && (owner == OWNER_D);

   assign i_waitrequest = i_req & ~i_done;
   assign d_waitrequest = d_req & ~d_done;

   assign i_readdata = i_done ? s_readdata : i_rdata_q;
   assign d_readdata = d_done ? s_readdata : d_rdata_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_valid) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (!s_waitrequest) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner        <= OWNER_I;
         last         <= OWNER_I;
         s_address    <= '0;
         s_read       <= 1'b0;
         s_write      <= 1'b0;
         s_byteenable <= '0;
         s_writedata  <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state <= state_nxt;

         if (state == IDLE && grant_valid) begin
            owner <= grant;
            if (grant == OWNER_D) begin
               s_address    <= d_address;
               s_byteenable <= d_byteenable;
               s_writedata  <= d_writedata;
               // A simultaneous read and write is treated as a write.
               s_write      <= d_write;
               s_read       <= ~d_write;
            end else begin
               s_address    <= i_address;
               s_byteenable <= '1;
               s_writedata  <= '0;
               s_write      <= 1'b0;
               s_read       <= 1'b1;
            end
         end

         if (completing) begin
            s_read  <= 1'b0;
            s_write <= 1'b0;
            last    <= owner;
            if (owner == OWNER_I) i_rdata_q <= s_readdata;
            else                  d_rdata_q <= s_readdata;
         end
      end
   end

endmodule

// File: tb/tb_mips_cpu_avalon_arbiter.sv
module tb_mips_cpu_avalon_arbiter;

`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] i_address;
   logic        i_read;
   logic        i_waitrequest;
   logic [31:0] i_readdata;
   logic [31:0] d_address;
   logic        d_read;
   logic        d_write;
   logic [3:0]  d_byteenable;
   logic [31:0] d_writedata;
   logic        d_waitrequest;
   logic [31:0] d_readdata;
   logic [31:0] s_address;
   logic        s_read;
   logic        s_write;
   logic [3:0]  s_byteenable;
   logic [31:0] s_writedata;
   logic        s_waitrequest;
   logic [31:0] s_readdata;

   int checks = 0;
   int failures = 0;

   // Slave model: stalls 'stall' WAIT cycles, optionally shows a stale low
   // waitrequest during the issue cycle.
   int unsigned stall = 0;
   bit          force_issue_low = 1'b0;
   int unsigned cnt = 0;
   logic [31:0] i_word_saved;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!(s_read || s_write)) cnt <= 0;
      else                      cnt <= cnt + 1;
   end

   assign s_waitrequest = (force_issue_low && (s_read || s_write) && cnt == 0) ? 1'b0 :
                          !((s_read || s_write) && (cnt >= stall + 1));
   assign s_readdata = mem_word(s_address);

   mips_cpu_avalon_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_address     (i_address),
      .i_read        (i_read),
      .i_waitrequest (i_waitrequest),
      .i_readdata    (i_readdata),
      .d_address     (d_address),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_byteenable  (d_byteenable),
      .d_writedata   (d_writedata),
      .d_waitrequest (d_waitrequest),
      .d_readdata    (d_readdata),
      .s_address     (s_address),
      .s_read        (s_read),
      .s_write       (s_write),
      .s_byteenable  (s_byteenable),
      .s_writedata   (s_writedata),
      .s_waitrequest (s_waitrequest),
      .s_readdata    (s_readdata)
   );

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (s_read !== 1'b0 || s_write !== 1'b0) begin
         failures++;
         $display("FAIL reset_rw got=%b%b exp=00", s_read, s_write);
      end
      checks++;
      if (s_address !== 32'h0 || s_byteenable !== 4'h0 || s_writedata !== 32'h0) begin
         failures++;
         $display("FAIL reset_bus got addr=%h be=%h wd=%h exp=0", s_address, s_byteenable, s_writedata);
      end
      checks++;
      if (i_readdata !== 32'h0 || d_readdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_rdata got i=%h d=%h exp=0", i_readdata, d_readdata);
      end
      checks++;
      if (i_waitrequest !== 1'b0 || d_waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL reset_wait got i=%b d=%b exp=0", i_waitrequest, d_waitrequest);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Request cycle plus two slave cycles: completion visible on the
   // second cycle after the request is seen.
   task automatic test_single_i_read();
      int rd_cycles = 0;
      int done_cyc = -1;
      stall = 0;
      i_address = 32'hBFC0_0000;
      i_read = 1'b1;
      for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (s_read) begin
            rd_cycles++;
            checks++;
            if (s_byteenable !== 4'hF || s_address !== 32'hBFC0_0000) begin
               failures++;
               $display("FAIL i_read_bus got be=%h addr=%h exp be=f addr=bfc00000", s_byteenable, s_address);
            end
         end
         if (!i_waitrequest) begin
            done_cyc = c;
            checks++;
            if (i_readdata !== mem_word(32'hBFC0_0000)) begin
               failures++;
               $display("FAIL i_read_data got=%h exp=%h", i_readdata, mem_word(32'hBFC0_0000));
            end
            i_read = 1'b0;
         end
      end
      i_word_saved = mem_word(32'hBFC0_0000);
      checks++;
      if (done_cyc != 2) begin
         failures++;
         $display("FAIL i_read_latency got=%0d exp=2", done_cyc);
      end
      checks++;
      if (rd_cycles != 2) begin
         failures++;
         $display("FAIL i_read_sread_cycles got=%0d exp=2", rd_cycles);
      end
      @(negedge clk);
      checks++;
      if (s_read !== 1'b0) begin
         failures++;
         $display("FAIL i_read_release got=%b exp=0", s_read);
      end
   endtask

   task automatic test_d_write();
      int wr_cycles = 0;
      int done_cyc = -1;
      stall = 4;
      d_address = 32'hBFC0_0010;
      d_byteenable = 4'b0011;
      d_writedata = 32'hDEAD_BEEF;
      d_write = 1'b1;
      for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (s_write) begin
            wr_cycles++;
            checks++;
            if (s_address !== 32'hBFC0_0010 || s_byteenable !== 4'b0011 ||
                s_writedata !== 32'hDEAD_BEEF || s_read !== 1'b0) begin
               failures++;
               $display("FAIL d_write_bus got addr=%h be=%h wd=%h rd=%b exp bfc00010/3/deadbeef/0",
                        s_address, s_byteenable, s_writedata, s_read);
            end
         end
         if (i_waitrequest !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL d_write_i_idle got=%b exp=0", i_waitrequest);
         end
         if (!d_waitrequest) begin
            done_cyc = c;
            d_write = 1'b0;
         end
      end
      checks++;
      if (done_cyc != 6) begin
         failures++;
         $display("FAIL d_write_latency got=%0d exp=6", done_cyc);
      end
      checks++;
      if (wr_cycles != 6) begin
         failures++;
         $display("FAIL d_write_swrite_cycles got=%0d exp=6", wr_cycles);
      end
      checks++;
      if (i_readdata !== i_word_saved) begin
         failures++;
         $display("FAIL i_rdata_hold got=%h exp=%h", i_readdata, i_word_saved);
      end
      @(negedge clk);
      checks++;
      if (s_write !== 1'b0) begin
         failures++;
         $display("FAIL d_write_release got=%b exp=0", s_write);
      end
   endtask

   // Previous transfer was D, so round-robin favours I; fixed favours D.
   task automatic test_contention();
      int ic = -1;
      int dc = -1;
      int i_exp = RR ? 2 : 5;
      int d_exp = RR ? 5 : 2;
      stall = 0;
      i_address = 32'h1000_0040;
      d_address = 32'h2000_0080;
      d_byteenable = 4'hF;
      i_read = 1'b1;
      d_read = 1'b1;
      for (int c = 1; c <= 20 && (ic < 0 || dc < 0); c++) begin
         @(negedge clk);
         if (i_read && !i_waitrequest) begin
            ic = c;
            checks++;
            if (i_readdata !== mem_word(32'h1000_0040)) begin
               failures++;
               $display("FAIL contend_i_data got=%h exp=%h", i_readdata, mem_word(32'h1000_0040));
            end
            i_read = 1'b0;
         end
         if (d_read && !d_waitrequest) begin
            dc = c;
            checks++;
            if (d_readdata !== mem_word(32'h2000_0080)) begin
               failures++;
               $display("FAIL contend_d_data got=%h exp=%h", d_readdata, mem_word(32'h2000_0080));
            end
            d_read = 1'b0;
         end
      end
      checks++;
      if (ic != i_exp || dc != d_exp) begin
         failures++;
         $display("FAIL contend_order got i=%0d d=%0d exp i=%0d d=%0d", ic, dc, i_exp, d_exp);
      end
      i_read = 1'b0;
      d_read = 1'b0;
      @(negedge clk);
   endtask

   // Both masters keep requesting for ten completions. Round-robin starts
   // with I (last completed was D) and alternates; fixed never grants I.
   task automatic test_back_to_back();
      int done = 0;
      int g = 0;
      int n_i = 0;
      int last_issue = -1;
      bit prev = 1'b0;
      bit is_i, exp_i;
      stall = 0;
      i_address = 32'h1000_0000;
      d_address = 32'h2000_0000;
      i_read = 1'b1;
      d_read = 1'b1;
      for (int c = 1; c <= 200 && done < 10; c++) begin
         @(negedge clk);
         if (s_read && !prev) begin
            is_i = (s_address[31:28] == 4'h1);
            exp_i = RR ? (g % 2 == 0) : 1'b0;
            checks++;
            if (is_i !== exp_i) begin
               failures++;
               $display("FAIL b2b_grant%0d got_i=%b exp_i=%b", g, is_i, exp_i);
            end
            if (last_issue >= 0) begin
               checks++;
               if (c - last_issue != 3) begin
                  failures++;
                  $display("FAIL b2b_spacing%0d got=%0d exp=3", g, c - last_issue);
               end
            end
            last_issue = c;
            if (is_i) n_i++;
            g++;
         end
         prev = s_read;
         if (d_read && !d_waitrequest) begin
            checks++;
            if (d_readdata !== mem_word(d_address)) begin
               failures++;
               $display("FAIL b2b_d_data got=%h exp=%h", d_readdata, mem_word(d_address));
            end
            done++;
            d_address = d_address + 32'd4;
         end
         if (i_read && !i_waitrequest) begin
            checks++;
            if (i_readdata !== mem_word(i_address)) begin
               failures++;
               $display("FAIL b2b_i_data got=%h exp=%h", i_readdata, mem_word(i_address));
            end
            done++;
            i_address = i_address + 32'd4;
         end
         if (done >= 10) begin
            i_read = 1'b0;
            d_read = 1'b0;
         end
      end
      checks++;
      if (done != 10 || g != 10) begin
         failures++;
         $display("FAIL b2b_count got done=%0d grants=%0d exp 10/10", done, g);
      end
      checks++;
      if (n_i != (RR ? 5 : 0)) begin
         failures++;
         $display("FAIL b2b_i_grants got=%0d exp=%0d", n_i, RR ? 5 : 0);
      end
      i_read = 1'b0;
      d_read = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int done_cyc = -1;
      stall = 10;
      d_address = 32'h2000_1000;
      d_read = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (s_read !== 1'b1 || d_waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre got rd=%b wait=%b exp 1/1", s_read, d_waitrequest);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (s_read !== 1'b0 || s_write !== 1'b0 || d_readdata !== 32'h0) begin
         failures++;
         $display("FAIL rst_mid_clear got rd=%b wr=%b rdata=%h exp 0/0/0", s_read, s_write, d_readdata);
      end
      rst_n = 1'b1;
      stall = 0;
      for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (!d_waitrequest) begin
            done_cyc = c;
            checks++;
            if (d_readdata !== mem_word(32'h2000_1000)) begin
               failures++;
               $display("FAIL rst_mid_data got=%h exp=%h", d_readdata, mem_word(32'h2000_1000));
            end
            d_read = 1'b0;
         end
      end
      checks++;
      if (done_cyc != 2) begin
         failures++;
         $display("FAIL rst_mid_latency got=%0d exp=2", done_cyc);
      end
      d_read = 1'b0;
      @(negedge clk);
   endtask

   // Stale low waitrequest at ISSUE, then high for two WAIT cycles.
   task automatic test_stale_issue();
      int done_cyc = -1;
      force_issue_low = 1'b1;
      stall = 2;
      i_address = 32'h1000_2000;
      i_read = 1'b1;
      for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checks++;
            if (i_waitrequest !== 1'b1) begin
               failures++;
               $display("FAIL stale_issue_wait got=%b exp=1", i_waitrequest);
            end
         end
         if (!i_waitrequest) begin
            done_cyc = c;
            checks++;
            if (i_readdata !== mem_word(32'h1000_2000)) begin
               failures++;
               $display("FAIL stale_issue_data got=%h exp=%h", i_readdata, mem_word(32'h1000_2000));
            end
            i_read = 1'b0;
         end
      end
      checks++;
      if (done_cyc != 4) begin
         failures++;
         $display("FAIL stale_issue_latency got=%0d exp=4", done_cyc);
      end
      i_read = 1'b0;
      force_issue_low = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      i_address = '0;
      i_read = 1'b0;
      d_address = '0;
      d_read = 1'b0;
      d_write = 1'b0;
      d_byteenable = '0;
      d_writedata = '0;
      test_reset();
      test_single_i_read();
      test_d_write();
      test_contention();
      test_back_to_back();
      test_reset_mid();
      test_stale_issue();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
